// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver
// ---------------
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock)
// driving DIGITS time-multiplexed 7-segment digits.
//
// Ports:
//   CLK    in   system clock
//   RST_N  in   asynchronous active-low reset
//   VALUE  in   [IN_W-1:0] unsigned value, sampled on LOAD while idle
//   LOAD   in   single-cycle strobe; ignored while BUSY=1
//   BUSY   out  conversion in progress
//   SEG    out  [6:0] segments {a,b,c,d,e,f,g}, SEG[6]=a
//   AN     out  [DIGITS-1:0] digit enables, AN[0] = units digit
//   OVF    out  committed value needs more than DIGITS decimal digits
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (above digit 0) are blanked
//   undefined -> every digit is shown, including leading zeros
module seg7_mux_driver #(
    parameter int IN_W           = 8,
    parameter int DIGITS         = 3,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [IN_W-1:0]   VALUE,
    input  logic              LOAD,
    output logic              BUSY,
    output logic [6:0]        SEG,
    output logic [DIGITS-1:0] AN,
    output logic              OVF
);

    localparam int BCD_INT = (IN_W * 3) / 10 + 1;
    localparam int BCD_W   = BCD_INT * 4;
    localparam int DISP_W  = DIGITS * 4;
    localparam int CP      = (DIGITS < BCD_INT) ? DIGITS : BCD_INT;
    localparam int CNT_W   = $clog2(IN_W + 1);
    localparam int REF_W   = $clog2(REFRESH_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

    localparam logic [6:0]        SEG_RST = (SEG_ACTIVE_LOW != 0) ? SEG_ZERO : ~SEG_ZERO;
    localparam logic [DIGITS-1:0] AN_RST  = (AN_ACTIVE_LOW != 0) ? ~DIGITS'(1) : DIGITS'(1);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // After reset the value is 0, so everything except digit 0 is blank.
    localparam logic [DIGITS-1:0] MASK_RST = ~DIGITS'(1);
`else
    localparam logic [DIGITS-1:0] MASK_RST = '0;
`endif

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    // Active-low segment pattern for one BCD nibble; 10..15 decode blank.
    function automatic logic [6:0] dec_al(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_t            state_q, state_d;
    logic [IN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic [DIGITS-1:0] mask_q, mask_d;
    logic              ovf_q, ovf_d;
    logic [REF_W-1:0]  ref_q, ref_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+IN_W-1:0]  shifted;
    logic [DISP_W-1:0]      commit_digits;
    logic [DIGITS-1:0]      commit_mask;
    logic                   commit_ovf;

    // ---------------- conversion datapath ----------------
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_INT; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Digits that land in the display; any missing upper digits are zero.
    always_comb begin
        commit_digits = '0;
        commit_digits[CP*4-1:0] = bcd_q[CP*4-1:0];
    end

    generate
        if (BCD_INT > DIGITS) begin : g_ovf
            assign commit_ovf = |bcd_q[BCD_W-1:DISP_W];
        end else begin : g_no_ovf
            assign commit_ovf = 1'b0;
        end
    endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic nz_acc;
    // Walk from the top digit down; a digit is blank while everything at
    // and above it is zero. Digit 0 is never blanked.
    always_comb begin
        commit_mask = '0;
        nz_acc      = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            nz_acc         = nz_acc | (commit_digits[i*4 +: 4] != 4'd0);
            commit_mask[i] = ~nz_acc;
        end
    end
`else
    assign commit_mask = '0;
`endif

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        mask_d  = mask_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (LOAD) begin
                    bin_d   = VALUE;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(IN_W);
                    state_d = CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = shifted;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = COMMIT;
            end
            COMMIT: begin
                disp_d  = commit_digits;
                mask_d  = commit_mask;
                ovf_d   = commit_ovf;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- refresh scan ----------------
    logic       ref_wrap;
    logic [3:0] cur_nib;
    logic [6:0] seg_al;

    always_comb begin
        ref_wrap = (ref_q == REF_W'(REFRESH_DIV - 1));
        ref_d    = ref_wrap ? '0 : ref_q + REF_W'(1);
        idx_d    = idx_q;
        if (ref_wrap)
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // SEG/AN are built from next-state display data so a commit and the
    // digit it affects reach the pins on the same edge; the display
    // register only changes at COMMIT, so no partial value is ever shown.
    always_comb begin
        cur_nib = disp_d[idx_d*4 +: 4];
        if (ovf_d)
            seg_al = SEG_DASH;
        else if (mask_d[idx_d])
            seg_al = SEG_BLANK;
        else
            seg_al = dec_al(cur_nib);
        seg_d = (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;
        an_d  = (AN_ACTIVE_LOW != 0) ? ~(DIGITS'(1) << idx_d) : (DIGITS'(1) << idx_d);
    end

    // ---------------- registers ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            mask_q  <= MASK_RST;
            ovf_q   <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_RST;
            an_q    <= AN_RST;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign BUSY = (state_q != IDLE);
    assign OVF  = ovf_q;
    assign SEG  = seg_q;
    assign AN   = an_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Self-checking bench for seg7_mux_driver: two instances (3 and 2 digits,
// REFRESH_DIV=4), table-driven conversions plus hand-written corner cases.
module tb_seg7_mux_driver;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SD = 7'b1111110;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b0000001;
`endif

    logic       clk, rst_n;
    logic [7:0] valA, valB;
    logic       loadA, loadB, busyA, busyB, ovfA, ovfB;
    logic [6:0] segA, segB;
    logic [2:0] anA;
    logic [1:0] anB;

    int errors = 0;
    int checks = 0;

    seg7_mux_driver #(.IN_W(8), .DIGITS(3), .REFRESH_DIV(4)) dutA (
        .CLK(clk), .RST_N(rst_n), .VALUE(valA), .LOAD(loadA),
        .BUSY(busyA), .SEG(segA), .AN(anA), .OVF(ovfA));

    seg7_mux_driver #(.IN_W(8), .DIGITS(2), .REFRESH_DIV(4)) dutB (
        .CLK(clk), .RST_N(rst_n), .VALUE(valB), .LOAD(loadB),
        .BUSY(busyB), .SEG(segB), .AN(anB), .OVF(ovfB));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         sel;
        logic [7:0] value;
        logic       ovf;
        logic [6:0] d2, d1, d0;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_load(input int sel, input logic [7:0] v);
        @(posedge clk); #1;
        if (sel == 1) begin valB = v; loadB = 1'b1; end
        else begin valA = v; loadA = 1'b1; end
        @(posedge clk); #1;
        loadA = 1'b0;
        loadB = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel == 1) ? busyB : busyA) && n < 60);
        if (n >= 60) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    // Scan two full refresh rounds, recording the segments seen per digit.
    task automatic capture(input int sel, output logic [6:0] s2, output logic [6:0] s1,
                           output logic [6:0] s0, output logic onehot_ok);
        logic [2:0] an;
        logic [6:0] sg;
        s2 = 7'h55; s1 = 7'h55; s0 = 7'h55;
        onehot_ok = 1'b1;
        repeat (24) begin
            @(negedge clk);
            an = (sel == 1) ? {1'b1, anB} : anA;
            sg = (sel == 1) ? segB : segA;
            case (an)
                3'b110:  s0 = sg;
                3'b101:  s1 = sg;
                3'b011:  s2 = sg;
                default: onehot_ok = 1'b0;
            endcase
        end
    endtask

    initial begin
        logic [6:0] c2, c1, c0;
        logic       oh;
        logic [2:0] prev;
        int         n;

        vecs[0]  = '{0, 8'd207, 1'b0, S2, S0, S7};
        vecs[1]  = '{0, 8'd0,   1'b0, LZ, LZ, S0};
        vecs[2]  = '{0, 8'd5,   1'b0, LZ, LZ, S5};
        vecs[3]  = '{0, 8'd99,  1'b0, LZ, S9, S9};
        vecs[4]  = '{0, 8'd128, 1'b0, S1, S2, S8};
        vecs[5]  = '{0, 8'd255, 1'b0, S2, S5, S5};
        vecs[6]  = '{1, 8'd255, 1'b1, 7'h55, SD, SD};
        vecs[7]  = '{1, 8'd42,  1'b0, 7'h55, S4, S2};
        vecs[8]  = '{1, 8'd100, 1'b1, 7'h55, SD, SD};
        vecs[9]  = '{1, 8'd99,  1'b0, 7'h55, S9, S9};
        vecs[10] = '{1, 8'd7,   1'b0, 7'h55, LZ, S7};
        vecs[11] = '{0, 8'd10,  1'b0, LZ, S1, S0};

        rst_n = 1'b0; valA = '0; valB = '0; loadA = 1'b0; loadB = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset asserted mid-refresh takes effect without a clock edge.
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_an", 32'(anA), 32'(3'b110));
        chk("rst_async_seg", 32'(segA), 32'(S0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busyA), 32'd0);
        chk("rst_ovf", 32'(ovfA), 32'd0);
        chk("rst_an", 32'(anA), 32'(3'b110));
        chk("rst_seg", 32'(segA), 32'(S0));

        // Refresh: AN holds 4 cycles, then rotates 110 -> 101 -> 011 -> 110.
        prev = anA;
        n = 0;
        do begin @(negedge clk); n++; end while (anA == prev && n < 20);
        prev = anA;
        for (int k = 0; k < 3; k++) begin
            logic [2:0] exp_an;
            exp_an = {prev[1:0], prev[2]};
            n = 0;
            do begin @(negedge clk); n++; end while (anA == prev && n < 20);
            chk("refresh_period", 32'(n), 32'd4);
            chk("refresh_pattern", 32'(anA), 32'(exp_an));
            prev = anA;
        end

        // Table-driven conversions.
        for (int i = 0; i < 12; i++) begin
            do_load(vecs[i].sel, vecs[i].value);
            wait_idle(vecs[i].sel);
            capture(vecs[i].sel, c2, c1, c0, oh);
            chk($sformatf("vec%0d_ovf", i),
                32'((vecs[i].sel == 1) ? ovfB : ovfA), 32'(vecs[i].ovf));
            chk($sformatf("vec%0d_d0", i), 32'(c0), 32'(vecs[i].d0));
            chk($sformatf("vec%0d_d1", i), 32'(c1), 32'(vecs[i].d1));
            if (vecs[i].sel == 0)
                chk($sformatf("vec%0d_d2", i), 32'(c2), 32'(vecs[i].d2));
            chk($sformatf("vec%0d_onehot", i), 32'(oh), 32'd1);
        end

        // BUSY stays high IN_W+1 = 9 cycles after the LOAD edge.
        do_load(0, 8'd207);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!busyA) break;
            n++;
        end
        chk("busy_length", 32'(n), 32'd9);

        // Second LOAD while busy is dropped.
        do_load(0, 8'd15);
        repeat (2) @(posedge clk);
        #1 valA = 8'd99; loadA = 1'b1;
        @(posedge clk); #1 loadA = 1'b0;
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("drop_busy_idle", 32'(busyA), 32'd0);
        capture(0, c2, c1, c0, oh);
        chk("drop_d2", 32'(c2), 32'(LZ));
        chk("drop_d1", 32'(c1), 32'(S1));
        chk("drop_d0", 32'(c0), 32'(S5));

        // LOAD coinciding with the COMMIT cycle is dropped.
        do_load(0, 8'd42);
        repeat (8) @(posedge clk);
        #1;
        chk("commit_cycle_busy", 32'(busyA), 32'd1);
        valA = 8'd99; loadA = 1'b1;
        @(posedge clk); #1 loadA = 1'b0;
        chk("commit_busy_cleared", 32'(busyA), 32'd0);
        repeat (2) @(negedge clk);
        chk("commit_load_dropped", 32'(busyA), 32'd0);
        capture(0, c2, c1, c0, oh);
        chk("commit_d1", 32'(c1), 32'(S4));
        chk("commit_d0", 32'(c0), 32'(S2));

        // Reset mid-conversion aborts and shows 0.
        do_load(0, 8'd207);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midconv_busy", 32'(busyA), 32'd0);
        capture(0, c2, c1, c0, oh);
        chk("midconv_d2", 32'(c2), 32'(LZ));
        chk("midconv_d1", 32'(c1), 32'(LZ));
        chk("midconv_d0", 32'(c0), 32'(S0));
        chk("midconv_ovf", 32'(ovfA), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_mux_driver.md
Name: seg7_mux_driver

Overview:
- Parametrised successor to the two-digit combinational 7-segment decoder.
- Accepts an IN_W-bit unsigned binary value on a LOAD strobe and converts it to BCD sequentially (shift-add-3, one bit per clock).
- Drives DIGITS time-multiplexed 7-segment digits through shared segment lines plus one anode line per digit.
- Sits between the ADC/measurement datapath and the board's multiplexed display.

Parameters:
- IN_W, 8: width of the binary input value (4..16).
- DIGITS, 3: number of physical display digits (1..5).
- REFRESH_DIV, 50000: CLK cycles each digit stays lit before advancing (>=2).
- SEG_ACTIVE_LOW, 1: 1 means segment lines are active-low (0 lights the segment); 0 inverts SEG.
- AN_ACTIVE_LOW, 1: 1 means the selected anode is driven 0; 0 inverts AN.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- VALUE  in  IN_W  unsigned binary value to display.
- LOAD  in  1  single-cycle strobe; samples VALUE when BUSY=0.
- BUSY  out  1  conversion in progress; LOAD is ignored while high.
- SEG  out  7  segments {a,b,c,d,e,f,g}, SEG[6]=a ... SEG[0]=g.
- AN  out  DIGITS  digit enables; AN[0] is the rightmost (units) digit.
- OVF  out  1  high when the committed value needs more than DIGITS decimal digits.

Behaviour:
- Reset: one clock; asynchronous, active-low.
- Reset values:
  - BUSY=0, OVF=0.
  - Displayed BCD register = 0.
  - Digit index = 0, refresh counter = 0.
  - AN selects digit 0 only; SEG shows "0" (active-low 0000001 when SEG_ACTIVE_LOW=1).
- Internal sizing: BCD_INT = (IN_W*3)/10 + 1 nibbles, enough to hold 2^IN_W - 1.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: on LOAD=1, capture VALUE into the shift register, clear the BCD accumulator, load bit counter = IN_W, set BUSY=1, go to CONV.
  - CONV: each cycle, first add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 and decrement the counter. When the counter reaches 0, go to COMMIT.
  - COMMIT: copy the low DIGITS nibbles to the displayed register. Set OVF=1 if any nibble above DIGITS-1 is nonzero, else OVF=0. Clear BUSY and return to IDLE.
- Latency: LOAD to updated display/OVF = IN_W+2 cycles. BUSY is high for IN_W+1 cycles.
- Display update is atomic: SEG never shows a partially converted value.
- LOAD during BUSY is dropped; there is no queueing. LOAD in the same cycle COMMIT clears BUSY is also dropped.
- Overflow: when OVF=1, every digit shows "-" (only segment g lit).
- Refresh:
  - Counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, digit index advances 0,1,...,DIGITS-1, then back to 0.
  - Exactly one AN bit is active at all times.
  - SEG and AN are registered and change on the same edge.
- Decode (active-low form), digits 0-9:
  - 0: 0000001, 1: 1001111, 2: 0010010, 3: 0000110, 4: 1001100
  - 5: 0100100, 6: 0100000, 7: 0001111, 8: 0000000, 9: 0000100
  - Dash: 1111110. Blank: 1111111.
  - Nibble values 10-15 cannot occur; decode them as blank.
- Reset mid-conversion: aborts the conversion and returns to the reset state; the display shows 0.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: leading zero digits are blanked, i.e. every digit above the most significant nonzero digit shows blank. Digit 0 is never blanked, so value 0 shows a single "0". Blanking is evaluated at COMMIT and stored as a per-digit mask. OVF dashes take priority over blanking.
- Undefined: all DIGITS digits are shown, including leading zeros.

Test Plan:
- Reset: hold RST_N=0 mid-refresh, release -> AN=110, SEG=0000001, BUSY=0, OVF=0 (defaults).
- Conversion: LOAD with VALUE=8'd207 -> BUSY high for 9 cycles; display digits 2,0,7 committed at cycle 10; scanning AN[2] shows 0010010, AN[1] shows 0000001, AN[0] shows 0001111.
- Overflow: DIGITS=2, VALUE=8'd255 -> OVF=1; both digits show 1111110. A following LOAD of VALUE=8'd42 -> OVF=0, digits show 4 and 2.
- LOAD during BUSY: LOAD VALUE=8'd15, then LOAD VALUE=8'd99 three cycles later -> display shows 15; the second LOAD is dropped.
- Refresh: REFRESH_DIV=4 -> AN advances every 4 cycles in the sequence 110, 101, 011, 110.
- Option: with SEG7_LEADING_ZERO_BLANK_EN defined, VALUE=8'd5 -> AN[2] and AN[1] show 1111111, AN[0] shows 0100100. Without the macro, they show 0000001, 0000001, 0100100.
